// File: rtl/ysyx_22050039_ifu.sv
// ysyx_22050039_ifu: instruction fetch unit.
// Owns the fetch PC and keeps at most one word-aligned read outstanding.
// Returned words are queued with their PC in a small FIFO that feeds decode.
// A redirect from execute moves the fetch PC, empties the FIFO and squashes
// any outstanding read, so its data is discarded when it arrives.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid, once raised, holds its payload stable until that
// transfer. The one exception is a redirect, which withdraws req_valid and
// inst_valid in the same cycle. Responses are never back-pressured.
module ysyx_22050039_ifu #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32,
    parameter int DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'('h8000_0000)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [XLEN-1:0]     req_addr,
    input  logic                rsp_valid,
    input  logic [INST_LEN-1:0] rsp_data,
    output logic                rsp_ready,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     inst_pc,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // IDLE: free to issue. WAIT: live read outstanding.
    // DROP: squashed read outstanding; its data is thrown away.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   target_pc;

    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [INST_LEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0]     pc_mem   [DEPTH];

    logic req_fire;
    logic push;
    logic pop;
    logic fifo_nonempty;

    // A new read is issued only when a FIFO slot is free for its data, so
    // the push at response time can never overflow.
    assign req_valid     = !rst && (state == S_IDLE) && (count < FULL) && !redirect_valid;
    assign req_addr      = fetch_pc;
    assign rsp_ready     = 1'b1;
    assign req_fire      = req_valid && req_ready;

    // Low two bits of the redirect target are dropped to keep word alignment.
    assign target_pc     = redirect_pc & ~XLEN'(3);

    // Only a live response is queued; a redirect in the same cycle kills it.
    assign push          = (state == S_WAIT) && rsp_valid && !redirect_valid;

    // The FIFO head is hidden from decode while a redirect is flushing it.
    assign fifo_nonempty = (count != '0);
    assign inst_valid    = fifo_nonempty && !redirect_valid;
    assign pop           = inst_valid && inst_ready;
    assign inst          = fifo_nonempty ? inst_mem[rd_ptr] : '0;
    assign inst_pc       = fifo_nonempty ? pc_mem[rd_ptr]   : '0;

    // Fetch FSM and PC: issue, wait for the word, or drain a squashed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target_pc;
            case (state)
                S_WAIT:  state <= rsp_valid ? S_IDLE : S_DROP;
                S_DROP:  state <= rsp_valid ? S_IDLE : S_DROP;
                default: state <= S_IDLE;
            endcase
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_fire) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (rsp_valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: the returned word is written alongside the PC it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= rsp_data;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

endmodule

// File: doc/ysyx_22050039_ifu.md
Name: ysyx_22050039_ifu

Overview:
Instruction fetch unit sitting directly upstream of the decode stage. Owns the fetch PC, issues one word-aligned instruction read at a time over a valid/ready memory request channel, and buffers returned instructions with their PC in a small FIFO. Presents them to decode through a valid/ready handshake. Accepts a redirect, sourced from the execute stage on taken jump/branch, which flushes the FIFO and squashes any in-flight fetch.

Parameters:
XLEN, 64, width of PC and addresses
INST_LEN, 32, instruction width
DEPTH, 2, instruction FIFO entries (power of 2, >=2)
RESET_PC, 64'h8000_0000, fetch PC after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_addr  out  XLEN  fetch address, low 2 bits always 0
rsp_valid  in  1  read data returned (one per accepted request)
rsp_data  in  INST_LEN  returned instruction word
rsp_ready  out  1  tied 1; responses never back-pressured
inst_valid  out  1  FIFO head valid toward decode
inst_ready  in  1  decode consumes head
inst  out  INST_LEN  FIFO head instruction
inst_pc  out  XLEN  PC of FIFO head
redirect_valid  in  1  next-PC override (taken jump/branch)
redirect_pc  in  XLEN  new fetch PC; bits[1:0] ignored, forced 0

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, state=IDLE, FIFO count=0, rd/wr pointers=0. Outputs during/after reset: req_valid=0 while rst high, then req_valid=1 and req_addr=RESET_PC; inst_valid=0, inst=0, inst_pc=0 when empty.
- FSM states: IDLE, WAIT, DROP. At most one request outstanding.
- req_valid = (state==IDLE) && (count<DEPTH) && !redirect_valid; req_addr = fetch_pc; both held stable until req_ready.
- IDLE: req fire (req_valid&&req_ready) -> latch req_pc=fetch_pc, fetch_pc+=4 (mod 2^XLEN, wraps), go WAIT.
- WAIT: rsp_valid -> push {req_pc, rsp_data}, go IDLE. Push always has room, because the issue condition reserved a slot.
- DROP: rsp_valid -> discard data, go IDLE.
- Redirect (highest priority, any state): fetch_pc=redirect_pc&~3; count=0, pointers=0; no pop that cycle.
  - In IDLE: stay IDLE; no request issued that cycle.
  - In WAIT without rsp_valid: go DROP.
  - In WAIT with rsp_valid the same cycle: data discarded, go IDLE.
  - In DROP: stay DROP, or go IDLE if rsp_valid.
- Output: inst_valid = (count!=0) && !redirect_valid; inst/inst_pc = head entry. Pop on inst_valid&&inst_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. The FIFO never overflows; pop on empty is impossible (gated by inst_valid).
- Latency: req fire at T, rsp at T+k (k>=1), inst_valid at T+k+1. With req_ready and rsp_valid both immediate, sustained throughput is one instruction per 2 cycles.
- Reset mid-operation: all in-flight state lost. A response arriving after reset deassert while in IDLE is ignored (rsp_valid only honoured in WAIT/DROP).

Test Plan:
- Reset then req_ready=1, memory returns 32'h00000413 one cycle after fire -> req_addr=0x8000_0000; inst_valid rises 2 cycles after fire with inst=0x00000413, inst_pc=0x8000_0000; next req_addr=0x8000_0004.
- inst_ready=0, memory always responds -> FIFO fills with PCs 0x8000_0000 and 0x8000_0004; req_valid then stays 0. One pop -> exactly one new request, to 0x8000_0008.
- Redirect to 0x8000_0102 while in WAIT; response arrives 3 cycles later -> response dropped, inst_valid stays 0; next req_addr=0x8000_0100; FIFO empty.
- Redirect in the same cycle as rsp_valid with 1 entry queued -> count=0, inst_valid=0 that cycle and the next; next request to the redirect target.
- Simultaneous push and pop at count=1 -> count stays 1; head advances to the newer PC in order; no loss or duplication over 100 random-stall instructions against a scoreboard.
- Assert rst asynchronously mid-WAIT -> outputs return to reset values without a clock edge; after release, fetch restarts at 0x8000_0000.
